sram_arbiter_2p: RTL
====================

SRAM_ARBITER_2P -- requirements
Module: sram_arbiter_2p

Interface
REQ-001 SHALL have parameter AW, default 4, RAM address width in bits (depth 2**AW).
REQ-002 SHALL have parameter DW, default 8, RAM data width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports req0/req1  input  1  per-requester access request, held until granted.
REQ-006 SHALL have ports we0/we1  input  1  per-requester operation: 1 write, 0 read.
REQ-007 SHALL have ports addr0/addr1  input  AW  per-requester address.
REQ-008 SHALL have ports wdata0/wdata1  input  DW  per-requester write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  combinational accept pulse; the request is consumed on the clock edge ending this cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-return strobe.
REQ-011 SHALL have ports rdata0/rdata1  output  DW  read return data, qualified by rvalidN.
REQ-012 SHALL have port busy  output  1  high while the init sweep runs.
REQ-013 SHALL have ports ram_we  output  1, ram_addr  output  AW, ram_din  output  DW, driving a synchronous RAM (write on edge when ram_we=1; otherwise ram_dout registers mem[ram_addr] on that edge).
REQ-014 SHALL have port ram_dout  input  DW  RAM registered read data.

Function
REQ-015 SHALL implement states INIT and RUN.
REQ-016 In INIT: ram_we=1, ram_addr=init counter, ram_din=0, gnt0=gnt1=0, busy=1; counter increments each cycle from 0.
REQ-017 INIT -> RUN on the edge where the counter equals 2**AW-1 (exactly 2**AW INIT cycles); counter wraps to 0.
REQ-018 In RUN: busy=0; at most one of gnt0/gnt1 high per cycle; gntN=1 only if reqN=1.
REQ-019 Single requester in RUN SHALL be granted in the same cycle (zero-wait).
REQ-020 Both requesting SHALL grant the port holding priority; priority pointer SHALL move to the other port after any grant (round-robin); no grant leaves the pointer unchanged.
REQ-021 During a grant cycle ram_we, ram_addr, ram_din SHALL equal the granted port's weN, addrN, wdataN; with no grant ram_we=0 and ram_addr/ram_din hold their last values (no spurious write).
REQ-022 A read granted in cycle T SHALL produce rvalidN=1 and rdataN=ram_dout in cycle T+1 on the granting port only; the other port's rvalid stays 0.
REQ-023 Back-to-back reads (any port mix) SHALL sustain one grant per cycle with each return correctly tagged.
REQ-024 rdataN SHALL hold its last returned value when rvalidN=0.
REQ-025 A write granted then a read of the same address in the next cycle SHALL return the new data.
REQ-026 Requests asserted during INIT SHALL be held off (not lost); they are served from the first RUN cycle.

Reset
REQ-027 rst=1 at an edge SHALL set state=INIT, init counter=0, priority=port 0, rvalid0=rvalid1=0, rdata0=rdata1=0, tracked read tag cleared.
REQ-028 rst asserted mid-sweep or mid-read SHALL restart the full sweep; a read granted in the cycle of reset SHALL NOT produce rvalid.

Verification
REQ-029 Reset release -> busy=1 for exactly 16 cycles, ram_we=1 with ram_addr 0..15, ram_din=0; then busy=0.
REQ-030 After init, req0 read addr 5 -> gnt0 same cycle, rvalid0=1 rdata0=0x00 next cycle; rvalid1=0.
REQ-031 req0 write addr 3 = 0xA5, then req1 read addr 3 -> gnt1 next cycle, rvalid1=1 rdata1=0xA5 following cycle.
REQ-032 req0 and req1 held high for 4 cycles (both reads) -> grants alternate 0,1,0,1; returns tagged accordingly.
REQ-033 req1 held during INIT -> gnt1 in first RUN cycle, not earlier.
REQ-034 rst pulsed during a read grant at sweep count 0 done -> no rvalid, sweep restarts at ram_addr 0, priority back to port 0.

Source files
------------

// File: rtl/sram_arbiter_2p.sv
// Two-port round-robin arbiter in front of a single synchronous RAM.
// Zeroes the whole RAM after reset, then grants one request per cycle.
module sram_arbiter_2p #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          busy,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    // state   | meaning
    // ST_INIT | sweep writes zero to every address, requests held off
    // ST_RUN  | round-robin arbitration, one grant per cycle
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          prio_q, prio_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_tag_q, rd_tag_d;
    logic [AW-1:0] addr_hold_q, addr_hold_d;
    logic [DW-1:0] din_hold_q, din_hold_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;

    // The read tag selects which port sees the registered RAM output.
    assign rvalid0 = rd_pend_q & ~rd_tag_q;
    assign rvalid1 = rd_pend_q &  rd_tag_q;
    assign rdata0  = rvalid0 ? ram_dout : rdata0_q;
    assign rdata1  = rvalid1 ? ram_dout : rdata1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_tag_q    <= 1'b0;
            addr_hold_q <= '0;
            din_hold_q  <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            rd_pend_q   <= rd_pend_d;
            rd_tag_q    <= rd_tag_d;
            addr_hold_q <= addr_hold_d;
            din_hold_q  <= din_hold_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prio_d      = prio_q;
        rd_pend_d   = 1'b0;
        rd_tag_d    = rd_tag_q;
        addr_hold_d = addr_hold_q;
        din_hold_d  = din_hold_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        busy        = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = addr_hold_q;
        ram_din     = din_hold_q;

        if (rvalid0) begin
            rdata0_d = ram_dout;
        end
        if (rvalid1) begin
            rdata1_d = ram_dout;
        end

        unique case (state_q)
            ST_INIT: begin
                busy        = 1'b1;
                ram_we      = 1'b1;
                ram_addr    = cnt_q;
                ram_din     = '0;
                addr_hold_d = cnt_q;
                din_hold_d  = '0;
                cnt_d       = cnt_q + AW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // prio_q=0 favours port 0 on contention, prio_q=1 favours port 1.
                gnt0 = req0 & (~req1 | ~prio_q);
                gnt1 = req1 & (~req0 |  prio_q);
                if (gnt0) begin
                    ram_we      = we0;
                    ram_addr    = addr0;
                    ram_din     = wdata0;
                    addr_hold_d = addr0;
                    din_hold_d  = wdata0;
                    prio_d      = 1'b1;
                    rd_pend_d   = ~we0;
                    rd_tag_d    = 1'b0;
                end else if (gnt1) begin
                    ram_we      = we1;
                    ram_addr    = addr1;
                    ram_din     = wdata1;
                    addr_hold_d = addr1;
                    din_hold_d  = wdata1;
                    prio_d      = 1'b0;
                    rd_pend_d   = ~we1;
                    rd_tag_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
